// File: rtl/fwd_scoreboard.sv
// Forwarding and hazard scoreboard: tracks destination tags from EXE to writeback and
// derives operand forward selects, ID write-through bypass and load-use stalls.
module fwd_scoreboard #(
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pipe_en,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic [5*NUM_SRC-1:0]     id_rs,
  input  logic [NUM_SRC-1:0]       id_rs_used,
  input  logic [4:0]               id_rd,
  input  logic                     id_regwen,
  input  logic                     id_is_load,
  output logic                     load_use_stall,
  output logic [NUM_SRC-1:0]       id_fwd_wb,
  output logic [SEL_W*NUM_SRC-1:0] exe_fwd_sel,
  output logic                     exe_fwd_err,
  output logic [31:0]              stall_count
);

  // index 0 is EXE, index DEPTH is writeback
  logic                 st_valid  [DEPTH+1];
  logic                 st_regwen [DEPTH+1];
  logic                 st_load   [DEPTH+1];
  logic [4:0]           st_rd     [DEPTH+1];
  logic [5*NUM_SRC-1:0] exe_rs;
  logic [NUM_SRC-1:0]   exe_rs_used;

  logic exe_seen;
  logic id_seen;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= DEPTH; k++) begin
        st_valid[k]  <= 1'b0;
        st_regwen[k] <= 1'b0;
        st_load[k]   <= 1'b0;
        st_rd[k]     <= 5'd0;
      end
      exe_rs      <= '0;
      exe_rs_used <= '0;
      stall_count <= 32'd0;
    end else begin
      if (pipe_en) begin
        for (int k = DEPTH; k >= 1; k--) begin
          st_valid[k]  <= st_valid[k-1];
          st_regwen[k] <= st_regwen[k-1];
          st_load[k]   <= st_load[k-1];
          st_rd[k]     <= st_rd[k-1];
        end
        st_valid[0]  <= id_valid & ~load_use_stall & ~flush;
        st_regwen[0] <= id_regwen;
        st_load[0]   <= id_is_load;
        st_rd[0]     <= id_rd;
        exe_rs       <= id_rs;
        exe_rs_used  <= id_rs_used;
      end else if (flush) begin
        st_valid[0] <= 1'b0;
      end
      if (pipe_en && load_use_stall && stall_count != 32'hFFFF_FFFF)
        stall_count <= stall_count + 32'd1;
    end
  end

  // The youngest producer stage wins, so scan from stage 1 outwards and latch the first hit.
  always_comb begin
    exe_fwd_sel = '0;
    exe_fwd_err = 1'b0;
    exe_seen    = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      exe_seen = 1'b0;
      for (int k = 1; k <= DEPTH; k++) begin
        if (!exe_seen && st_valid[0] && exe_rs_used[i] && st_valid[k] && st_regwen[k] &&
            exe_rs[5*i +: 5] != 5'd0 && st_rd[k] == exe_rs[5*i +: 5]) begin
          exe_seen = 1'b1;
          exe_fwd_sel[SEL_W*i +: SEL_W] = SEL_W'(k);
          if (st_load[k] && k < LOAD_STAGE)
            exe_fwd_err = 1'b1;
        end
      end
    end
  end

  // A younger non-load writer of the same register shadows an older load behind it.
  always_comb begin
    load_use_stall = 1'b0;
    id_seen        = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      id_seen = 1'b0;
      for (int k = 0; k <= DEPTH; k++) begin
        if (!id_seen && id_rs_used[i] && st_valid[k] && st_regwen[k] &&
            id_rs[5*i +: 5] != 5'd0 && st_rd[k] == id_rs[5*i +: 5]) begin
          id_seen = 1'b1;
          if (id_valid && st_load[k] && k <= LOAD_STAGE - 2)
            load_use_stall = 1'b1;
        end
      end
    end
  end

  always_comb begin
    id_fwd_wb = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      id_fwd_wb[i] = id_rs_used[i] & st_valid[DEPTH] & st_regwen[DEPTH] &
                     (id_rs[5*i +: 5] != 5'd0) & (st_rd[DEPTH] == id_rs[5*i +: 5]);
    end
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the in-order integer pipeline. Successor to the fixed 2-stage combinational forwarding logic.
- Keeps its own registered tag pipeline (rd, regwen, is_load) for every stage from EXE to writeback.
- Generates forwarding selects for NUM_SRC source operands in EXE, ID write-through bypass, and load-use stall for any depth and load latency.
- Sits beside the datapath between decode and the operand muxes; also counts stall cycles.

Parameters:
- NUM_SRC, 2, source operands per instruction.
- DEPTH, 2, producer stages after EXE (stage 1 = MEM … stage DEPTH = WB). Legal range 1..7.
- LOAD_STAGE, 2, first stage index (1..DEPTH) at which load data can be forwarded.
- SEL_W, clog2(DEPTH+1), width of each forward select.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pipe_en  in  1  pipeline advance; 0 freezes all tags.
- flush  in  1  kills the instruction entering EXE at the next edge.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  5*NUM_SRC  ID source regs, src i at bits [5i+4:5i].
- id_rs_used  in  NUM_SRC  source i is actually read.
- id_rd  in  5  ID destination.
- id_regwen  in  1  ID writes rd.
- id_is_load  in  1  ID is a load.
- load_use_stall  out  1  hold PC/IF/ID; insert a bubble into EXE.
- id_fwd_wb  out  NUM_SRC  ID regfile read must take the WB result (write-through).
- exe_fwd_sel  out  SEL_W*NUM_SRC  per EXE source: 0 = own operand, k = result of stage k.
- exe_fwd_err  out  1  nearest EXE match is a load not yet at LOAD_STAGE (must never assert).
- stall_count  out  32  saturating count of cycles with load_use_stall=1 and pipe_en=1.

Behaviour:
- Tag = {valid, regwen, is_load, rd[4:0], rs[5*NUM_SRC-1:0], rs_used}. Registers: tag0 (EXE), tag1..tagDEPTH. Stages 1..DEPTH hold only {valid, regwen, is_load, rd}.
- "Producer match" at stage k for reg r: tag_k.valid & tag_k.regwen & tag_k.rd==r & r!=0. x0 never matches.
- Reset (async, immediate): all tag valid bits 0, stall_count 0. Hence all outputs are 0 during and after reset until new tags load.
- Edge with pipe_en=1:
  - tag_k ← tag_{k-1} for k=1..DEPTH.
  - tag0 ← ID fields if id_valid & ~load_use_stall & ~flush; otherwise tag0 ← bubble (valid=0).
- Edge with pipe_en=0: all tags hold, except flush=1 still clears tag0.valid. stall_count holds.
- Flush and stall together: a bubble enters EXE; stall_count still increments if pipe_en=1.
- exe_fwd_sel[i]:
  - Value is the smallest k in 1..DEPTH with a producer match on tag0.rs[i]; youngest producer wins.
  - 0 if tag0 invalid, rs_used[i]=0, or no match.
  - Purely combinational from registers (zero latency).
- exe_fwd_err: 1 if any used source's selected stage k holds a load with k < LOAD_STAGE.
- load_use_stall = id_valid & OR over used src i and k in 0..LOAD_STAGE-2 of:
  - the nearest producer match for id_rs[i] among stages 0..DEPTH is stage k, and
  - tag_k.is_load.
  - A younger non-load match shadows an older load.
  - With LOAD_STAGE=1, load_use_stall is constant 0.
- id_fwd_wb[i] = id_rs_used[i] & producer match at stage DEPTH on id_rs[i].
- stall_count saturates at 0xFFFF_FFFF; it does not wrap.

Test Plan:
- Reset asserted mid-stream with tags populated → all outputs 0 immediately, without waiting for clk. After release with no ID traffic, exe_fwd_sel=0 and stall_count=0.
- Defaults; add x5=… then sub x6,x5,x5 back-to-back, pipe_en=1 → next cycle exe_fwd_sel={1,1}. One instruction later → {2,2}.
- Defaults; lw x7 followed by add x8,x7,x0 → load_use_stall=1 for exactly 1 cycle and a bubble enters EXE. Then exe_fwd_sel[0]=2, exe_fwd_err=0, stall_count=1.
- Two writes to x9 in MEM (add) and WB (add), consumer in EXE → sel=1 (youngest wins). Consumer of x0 with an x0 writer in flight → sel=0, no stall.
- DEPTH=4, LOAD_STAGE=3; lw x3 then consumer → 2 stall cycles. pipe_en=0 during the 2nd stall → tags frozen, stall held, count increments only on enabled cycles.
- flush together with load_use_stall, then WB producer x4 with ID rs2=x4 → tag0 is a bubble. id_fwd_wb=2'b10.
